// File: rtl/wb_dmx_tx.sv
// Wishbone DMX512 transmitter: 512-slot frame buffer plus a BREAK/MAB/start-code/slot sequencer, 250 kbit/s 8N2.
// Define WB_DMX_TX_IRQ_EN to implement CTRL.IE and the intr output.
`timescale 1ns/1ps
module wb_dmx_tx #(
  parameter int clk_freq = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        dmx_tx,
  output logic        dmx_de,
  output logic        intr
);
  localparam int DIV = clk_freq / 250000;
  localparam int DW  = $clog2(DIV);

  typedef enum logic [2:0] {S_IDLE, S_BREAK, S_MAB, S_START, S_SLOT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [9:0]    idx_q, idx_d;
  logic [7:0]    chr_q, chr_d, nxt_q, nxt_d;
  logic          fpend_q, fpend_d, fvld_q, fvld_d;
  logic          en_q, en_d, loop_q, loop_d, done_q, done_d;
  logic [9:0]    slots_q, slots_d, slots_eff_q, slots_eff_d;
  logic [7:0]    start_q, start_d, brk_q, brk_d, brk_eff_q, brk_eff_d;
  logic [3:0]    mab_q, mab_d, mab_eff_q, mab_eff_d;
  logic          ack_q, ack_d, bufrd_q, bufrd_d, tx_q, tx_d, de_q, de_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [31:0]   mem_q;
  logic [31:0]   mem [128];
  logic          req, is_buf, tick, fetch_gnt, mem_we, mem_re, go_brk, ie_rd;
  logic [2:0]    reg_sel;
  logic [6:0]    mem_adr;
  logic          unused_adr;

`ifdef WB_DMX_TX_IRQ_EN
  logic ie_q, ie_d;
  assign intr  = done_q & ie_q;
  assign ie_rd = ie_q;
`else
  assign intr  = 1'b0;
  assign ie_rd = 1'b0;
`endif

  assign unused_adr = ^{wb_adr_i[31:12], wb_adr_i[1:0]};
  assign req        = wb_stb_i & wb_cyc_i & ~ack_q;
  assign is_buf     = (wb_adr_i[11:9] == 3'b100);
  assign reg_sel    = (wb_adr_i[11:5] == 7'd0) ? wb_adr_i[4:2] : 3'd7;
  assign tick       = (div_q == DW'(DIV - 1));
  // The sequencer's slot fetch borrows the buffer port only when the bus is not using it.
  assign fetch_gnt  = fpend_q & ~(req & is_buf);
  assign mem_we     = req & wb_we_i & is_buf;
  assign mem_re     = (req & ~wb_we_i & is_buf) | fetch_gnt;
  assign mem_adr    = (req & is_buf) ? wb_adr_i[8:2] : idx_q[8:2];

  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? (bufrd_q ? mem_q : rdat_q) : 32'd0;
  assign dmx_tx   = tx_q;
  assign dmx_de   = de_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (wb_sel_i[i]) mem[mem_adr][i*8 +: 8] <= wb_dat_i[i*8 +: 8];
    end
    if (mem_re) mem_q <= mem[mem_adr];
  end

  always_comb begin
    ack_d       = req;
    bufrd_d     = req & ~wb_we_i & is_buf;
    rdat_d      = '0;
    en_d        = en_q;
    loop_d      = loop_q;
    done_d      = done_q;
    slots_d     = slots_q;
    start_d     = start_q;
    brk_d       = brk_q;
    mab_d       = mab_q;
`ifdef WB_DMX_TX_IRQ_EN
    ie_d        = ie_q;
`endif
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DW'(1);
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    chr_d       = chr_q;
    nxt_d       = nxt_q;
    fpend_d     = fpend_q & ~fetch_gnt;
    fvld_d      = fetch_gnt;
    slots_eff_d = slots_eff_q;
    brk_eff_d   = brk_eff_q;
    mab_eff_d   = mab_eff_q;
    go_brk      = 1'b0;
    tx_d        = 1'b1;

    if (fvld_q) nxt_d = mem_q[{idx_q[1:0], 3'b000} +: 8];

    if (req & ~wb_we_i & ~is_buf) begin
      case (reg_sel)
        3'd0:    rdat_d = {29'd0, ie_rd, loop_q, en_q};
        3'd1:    rdat_d = {30'd0, done_q, state_q != S_IDLE};
        3'd2:    rdat_d = {22'd0, slots_q};
        3'd3:    rdat_d = {24'd0, start_q};
        3'd4:    rdat_d = {24'd0, brk_q};
        3'd5:    rdat_d = {28'd0, mab_q};
        default: rdat_d = '0;
      endcase
    end
    if (req & wb_we_i & ~is_buf) begin
      case (reg_sel)
        3'd0: begin
          en_d   = wb_dat_i[0];
          loop_d = wb_dat_i[1];
`ifdef WB_DMX_TX_IRQ_EN
          ie_d   = wb_dat_i[2];
`endif
        end
        3'd1:    if (wb_dat_i[1]) done_d = 1'b0;
        3'd2:    slots_d = wb_dat_i[9:0];
        3'd3:    start_d = wb_dat_i[7:0];
        3'd4:    brk_d   = wb_dat_i[7:0];
        3'd5:    mab_d   = wb_dat_i[3:0];
        default: ;
      endcase
    end

    // Every phase ends on a bit tick; a cleared EN is honoured only at those boundaries.
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (en_q) go_brk = 1'b1;
      end
      S_BREAK: if (tick) begin
        if (cnt_q == brk_eff_q - 8'd1) begin
          cnt_d   = '0;
          state_d = en_q ? S_MAB : S_IDLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_MAB: if (tick) begin
        if (cnt_q == {4'd0, mab_eff_q} - 8'd1) begin
          cnt_d   = '0;
          idx_d   = '0;
          chr_d   = start_q;
          state_d = en_q ? S_START : S_IDLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_START, S_SLOT: if (tick) begin
        if (cnt_q == 8'd10) begin
          cnt_d = '0;
          if (!en_q) state_d = S_IDLE;
          else if (idx_q == slots_eff_q) state_d = S_DONE;
          else begin
            state_d = S_SLOT;
            idx_d   = idx_q + 10'd1;
            chr_d   = nxt_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd9) fpend_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (en_q & loop_q) go_brk = 1'b1;
        else begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_brk) begin
      state_d     = S_BREAK;
      div_d       = '0;
      cnt_d       = '0;
      slots_eff_d = (slots_q > 10'd512) ? 10'd512 : slots_q;
      brk_eff_d   = (brk_q < 8'd22) ? 8'd22 : brk_q;
      mab_eff_d   = (mab_q < 4'd2) ? 4'd2 : mab_q;
    end

    de_d = (state_d != S_IDLE);
    case (state_d)
      S_BREAK: tx_d = 1'b0;
      S_START, S_SLOT: begin
        if (cnt_d == 8'd0)      tx_d = 1'b0;
        else if (cnt_d <= 8'd8) tx_d = chr_d[3'(cnt_d - 8'd1)];
        else                    tx_d = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  div_q <= '0;  cnt_q <= '0;  idx_q <= '0;
      chr_q <= '0;  nxt_q <= '0;  fpend_q <= 1'b0;  fvld_q <= 1'b0;
      en_q <= 1'b0;  loop_q <= 1'b0;  done_q <= 1'b0;
      slots_q <= '0;  start_q <= '0;  brk_q <= 8'd23;  mab_q <= 4'd3;
      slots_eff_q <= '0;  brk_eff_q <= 8'd22;  mab_eff_q <= 4'd2;
      ack_q <= 1'b0;  bufrd_q <= 1'b0;  rdat_q <= '0;
      tx_q <= 1'b1;  de_q <= 1'b0;
`ifdef WB_DMX_TX_IRQ_EN
      ie_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  div_q <= div_d;  cnt_q <= cnt_d;  idx_q <= idx_d;
      chr_q <= chr_d;  nxt_q <= nxt_d;  fpend_q <= fpend_d;  fvld_q <= fvld_d;
      en_q <= en_d;  loop_q <= loop_d;  done_q <= done_d;
      slots_q <= slots_d;  start_q <= start_d;  brk_q <= brk_d;  mab_q <= mab_d;
      slots_eff_q <= slots_eff_d;  brk_eff_q <= brk_eff_d;  mab_eff_q <= mab_eff_d;
      ack_q <= ack_d;  bufrd_q <= bufrd_d;  rdat_q <= rdat_d;
      tx_q <= tx_d;  de_q <= de_d;
`ifdef WB_DMX_TX_IRQ_EN
      ie_q <= ie_d;
`endif
    end
  end
endmodule
